// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad (Pmod KYPD layout). One column is driven low at a
// time; the four active-low row returns are synchronized, captured once per
// column step and assembled into a 16-bit frame. Whole frames are debounced
// and each newly accepted key is reported as a one-cycle strobe with its hex
// code. The last four accepted codes are kept in a shift history that feeds
// the seven-segment digit inputs.
//
// Optional feature: define KEYPAD_HISTORY_EN to build the digit history
// register. Without it, digits is tied to 16'h0000.
//
// Parameters:
//   SCAN_DIV        clock cycles per column step (>= 4)
//   DEBOUNCE_SCANS  consecutive identical frame results to accept a change (>= 1)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous, active-low reset
//   row[3:0]   in   row returns, active low, asynchronous to clk
//   col[3:0]   out  column drive, active low, exactly one bit low
//   key_code   out  code of the most recently accepted key
//   key_valid  out  one-cycle strobe when a new key is accepted
//   key_held   out  high while the debounced state is a single pressed key
//   digits     out  last four accepted codes, newest in [3:0]
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    // A frame result or debounced state: either no key, or one key with code.
    typedef struct packed {
        logic       is_key;
        logic [3:0] code;
    } key_state_t;

    localparam key_state_t KEY_NONE = '0;

    // Frame bit index is {row, column}; map it to the printed key legend.
    function automatic logic [3:0] key_of(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Registers
    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [15:0]      frame_q, frame_d;
    key_state_t       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_t       stable_q, stable_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;

    // Combinational helpers
    logic             sample;
    logic             frame_end;
    logic [3:0]       pressed;
    logic [15:0]      frame_now;
    logic [4:0]       n_down;
    logic [3:0]       hit_idx;
    logic             multi;
    key_state_t       res;

    assign sample    = (div_cnt_q == DIV_LAST);
    assign frame_end = sample && (col_idx_q == 2'd3);
    assign pressed   = ~row_sync_q;

    assign div_cnt_d = sample ? '0 : div_cnt_q + DIV_W'(1);
    assign col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

    // Capture this column's rows into the frame on the sample cycle. The
    // frame-end view merges the column-3 rows being captured right now so
    // the result is available without waiting another cycle.
    always_comb begin
        frame_d   = frame_q;
        frame_now = frame_q;
        for (int r = 0; r < 4; r++) begin
            if (sample) begin
                frame_d[{2'(r), col_idx_q}] = pressed[r];
            end
            frame_now[{2'(r), 2'd3}] = pressed[r];
        end
    end

    // Classify the completed frame.
    always_comb begin
        n_down  = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            n_down = n_down + 5'(frame_now[i]);
            if (frame_now[i]) begin
                hit_idx = 4'(i);
            end
        end
        multi = (n_down > 5'd1);
        if (n_down == 5'd0) begin
            res = KEY_NONE;
        end else begin
            res.is_key = 1'b1;
            res.code   = key_of(hit_idx);
        end
    end

    // Debounce and acceptance. Multi-key frames are ignored entirely, so a
    // ghosting chord never disturbs an ongoing count.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (frame_end && !multi) begin
            if (res == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cand_d = res;
                cnt_d  = CNT_W'(1);
            end
            if ((cnt_d == CNT_MAX) && (cand_d != stable_q)) begin
                stable_d = cand_d;
                if (cand_d.is_key) begin
                    key_valid_d = 1'b1;
                    key_code_d  = cand_d.code;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            frame_q     <= '0;
            cand_q      <= KEY_NONE;
            cnt_q       <= '0;
            stable_q    <= KEY_NONE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            div_cnt_q   <= div_cnt_d;
            col_idx_q   <= col_idx_d;
            frame_q     <= frame_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

`ifdef KEYPAD_HISTORY_EN
    logic [15:0] digits_q;

    // Shift in the new code on the same edge that raises key_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
        end else if (key_valid_d) begin
            digits_q <= {digits_q[11:0], key_code_d};
        end
    end

    assign digits = digits_q;
`else
    assign digits = 16'h0000;
`endif

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = stable_q.is_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3.
// A keypad plant turns the pressed-key matrix plus the DUT column drive into
// row returns. A frame-level model predicts every output from the key map and
// the "last N non-multi frame results agree" acceptance rule; a compare
// process checks the DUT against it on every falling edge, and a strobe
// scoreboard matches each key_valid against an expected code queue.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int BOUND    = (DEB + 1) * FRAME + 1;
  localparam int NONE     = 16;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  always #5 clk = ~clk;

  // Pressed keys, index = row*4 + column.
  logic [15:0] key_down = '0;

  // Keypad plant: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(key_down[r*4 +: 4] & ~col)) row[r] = 1'b0;
    end
  end

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  int          m_t      = 0;      // clock edges since reset release
  int          m_hist[$];         // recent non-multi frame results
  int          m_stable = NONE;
  logic        m_valid  = 1'b0;
  logic [3:0]  m_code   = 4'h0;
  logic        m_held   = 1'b0;
  logic [15:0] m_digits = 16'h0;
  logic [3:0]  exp_q[$];          // expected strobe codes

  task automatic frame_eval();
    int n;
    int idx;
    int res;
    bit agree;
    n   = 0;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (key_down[i]) begin
        n++;
        idx = i;
      end
    end
    if (n >= 2) return;
    res = (n == 0) ? NONE : keymap[idx];
    m_hist.push_back(res);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      agree = 1'b1;
      foreach (m_hist[j]) if (m_hist[j] != res) agree = 1'b0;
      if (agree && res != m_stable) begin
        m_stable = res;
        m_held   = (res != NONE);
        if (res != NONE) begin
          m_valid = 1'b1;
          m_code  = 4'(res);
          exp_q.push_back(4'(res));
`ifdef KEYPAD_HISTORY_EN
          m_digits = {m_digits[11:0], 4'(res)};
`endif
        end
      end
    end
  endtask

  // Keys only change right after a frame end, so the whole frame sees one
  // key set and it can be evaluated at the frame-end edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t      = 0;
        m_hist.delete();
        m_stable = NONE;
        m_valid  = 1'b0;
        m_code   = 4'h0;
        m_held   = 1'b0;
        m_digits = 16'h0;
        exp_q.delete();
      end else begin
        m_valid = 1'b0;
        if (m_t % FRAME == FRAME - 1) frame_eval();
        m_t++;
      end
    end
  end

  // ---------------- compare process + strobe scoreboard ----------------
  int         strobe_cnt = 0;
  logic [3:0] last_code  = 4'h0;

  initial begin
    logic [3:0] ec;
    forever begin
      @(negedge clk);
      ec = ~(4'b0001 << ((m_t / SCAN_DIV) % 4));
      check("col", 16'(col), 16'(ec));
      check("key_valid", 16'(key_valid), 16'(m_valid));
      check("key_code", 16'(key_code), 16'(m_code));
      check("key_held", 16'(key_held), 16'(m_held));
      check("digits", digits, m_digits);
      if (key_valid === 1'b1) begin
        strobe_cnt++;
        last_code = key_code;
        if (exp_q.size() == 0) check("strobe_unexpected", 16'd1, 16'd0);
        else check("strobe_code", 16'(key_code), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frames(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      while (m_t % FRAME != 0) @(negedge clk);
    end
    #1;
  endtask

  task automatic wait_strobe(input string name, input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (key_valid === 1'b1) found = 1'b1;
    end
    check(name, 16'(found), 16'd1);
  endtask

  task automatic wait_release(input string name, input int budget);
    int cycles;
    cycles = 0;
    while (key_held !== 1'b0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check(name, 16'(key_held), 16'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3:0]  walk [4];
    logic [3:0]  hist_idx [4];
    logic [15:0] hist_exp;
    int          s0;
    int          lat;

    walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_col", 16'(col), 16'h000E);
    check("rst_key_code", 16'(key_code), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_held", 16'(key_held), 16'h0);
    check("rst_digits", digits, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Column walk, 8 cycles per column
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("col_walk", 16'(col), 16'(walk[(k / 8) % 4]));
    end

    // Clean press of row1/col2 -> code 6
    s0 = strobe_cnt;
    key_down[6] = 1'b1;
    wait_strobe("press_strobe", BOUND, lat);
    check("press_latency_ok", 16'(lat <= BOUND), 16'd1);
    check("press_code", 16'(key_code), 16'h6);
    check("press_held", 16'(key_held), 16'd1);
    wait_frames(4);
    check("press_single_strobe", 16'(strobe_cnt - s0), 16'd1);
    check("press_still_held", 16'(key_held), 16'd1);
    key_down = '0;
    wait_release("release_held_low", BOUND);
    check("release_code_kept", 16'(key_code), 16'h6);

    // Bounce on row0/col0: toggle each frame, then hold
    wait_frames(1);
    s0 = strobe_cnt;
    for (int f = 0; f < 5; f++) begin
      key_down[0] = (f % 2 == 0);
      wait_frames(1);
    end
    check("bounce_no_strobe", 16'(strobe_cnt - s0), 16'd0);
    wait_frames(3);
    check("bounce_one_strobe", 16'(strobe_cnt - s0), 16'd1);
    check("bounce_code", 16'(last_code), 16'h1);
    check("bounce_held", 16'(key_held), 16'd1);
    key_down = '0;
    wait_frames(4);
    check("bounce_release", 16'(key_held), 16'd0);

    // Ghost: 5 and 9 together, then release 9
    s0 = strobe_cnt;
    key_down[5]  = 1'b1;
    key_down[10] = 1'b1;
    wait_frames(10);
    check("ghost_no_strobe", 16'(strobe_cnt - s0), 16'd0);
    check("ghost_not_held", 16'(key_held), 16'd0);
    key_down[10] = 1'b0;
    wait_frames(4);
    check("ghost_release_strobe", 16'(strobe_cnt - s0), 16'd1);
    check("ghost_code", 16'(last_code), 16'h5);
    check("ghost_held", 16'(key_held), 16'd1);

    // Async reset while key 5 is held
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_col", 16'(col), 16'h000E);
    check("areset_key_code", 16'(key_code), 16'h0);
    check("areset_key_valid", 16'(key_valid), 16'h0);
    check("areset_key_held", 16'(key_held), 16'h0);
    check("areset_digits", digits, 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_strobe("areset_restrobe", BOUND + FRAME, lat);
    check("areset_code", 16'(key_code), 16'h5);
    key_down = '0;
    wait_frames(4);
    wait_frames(4);
    check("areset_release", 16'(key_held), 16'd0);

    // History: press and release 1, 2, 3, A
    hist_idx[0] = 4'd0; hist_idx[1] = 4'd1; hist_idx[2] = 4'd2; hist_idx[3] = 4'd3;
    for (int i = 0; i < 4; i++) begin
      key_down = '0;
      key_down[hist_idx[i]] = 1'b1;
      wait_frames(4);
      key_down = '0;
      wait_frames(4);
    end
    check("hist_last_code", 16'(last_code), 16'hA);
`ifdef KEYPAD_HISTORY_EN
    hist_exp = 16'h123A;
`else
    hist_exp = 16'h0000;
`endif
    check("hist_digits", digits, hist_exp);

    check("pending_strobes", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
